// File: rtl/fir2d_pkg.sv
// Shared types and helpers for the 2-D filter row scheduler.
package fir2d_pkg;

   localparam int RES_W = 12;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRIME,
      ST_FEED,
      ST_FLUSH,
      ST_DONE
   } state_t;

   typedef struct packed {
      logic valid;
      logic row_last;
      logic frm_last;
   } tag_t;

   // Negative zero maps to 0 because -0 == 0 in two's complement.
   function automatic logic [RES_W-1:0] sm_to_tc(input logic [RES_W-1:0] sm);
      logic [RES_W-1:0] mag;
      mag = {1'b0, sm[RES_W-2:0]};
      return sm[RES_W-1] ? -mag : mag;
   endfunction

endpackage

// File: rtl/fir2d_tag_pipe.sv
// Delays the per-slot tag so it lines up with the filter output.
module fir2d_tag_pipe
   import fir2d_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  tag_t d,
   output tag_t q
);

   tag_t stage [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
         stage[0] <= d;
         for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign q = stage[DEPTH-1];

endmodule

// File: rtl/fir2d_row_sched.sv
// Row scheduler: primes/feeds/flushes the free-running 1-D FIR and frames its results.
module fir2d_row_sched
   import fir2d_pkg::*;
#(
   parameter int IMG_W    = 16,
   parameter int IMG_H    = 16,
   parameter int TAPS     = 4,
   parameter int FILT_LAT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             s_valid,
   input  logic [7:0]       s_data,
   output logic             s_ready,
   output logic [7:0]       fir_x,
   input  logic [RES_W-1:0] fir_y,
   output logic             m_valid,
   output logic [RES_W-1:0] m_data,
   output logic             m_row_last,
   output logic             m_frm_last,
   output logic             busy,
   output logic             done,
   output logic             err_unrun
);

   localparam int CW = $clog2(IMG_W + TAPS);
   localparam int RW = $clog2(IMG_H + 1);
   localparam logic [CW-1:0] EDGE_END = CW'(TAPS - 2);
   localparam logic [CW-1:0] FEED_END = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_END  = RW'(IMG_H - 1);

   state_t          state, state_n;
   logic [CW-1:0]   col_cnt, col_n;
   logic [RW-1:0]   row_cnt, row_n;
   logic            start_ok;
   tag_t            tag_in, tag_out;

   // DONE also accepts start so a back-to-back frame loses no cycle.
   assign start_ok = start && (state == ST_IDLE || state == ST_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         col_cnt <= '0;
         row_cnt <= '0;
      end else begin
         state   <= state_n;
         col_cnt <= col_n;
         row_cnt <= row_n;
      end
   end

   always_comb begin
      state_n = state;
      col_n   = col_cnt;
      row_n   = row_cnt;
      case (state)
         ST_IDLE: begin
            if (start_ok) state_n = ST_PRIME;
         end
         ST_PRIME: begin
            if (col_cnt == EDGE_END) begin
               state_n = ST_FEED;
               col_n   = '0;
            end else begin
               col_n = col_cnt + 1'b1;
            end
         end
         ST_FEED: begin
            if (col_cnt == FEED_END) begin
               state_n = ST_FLUSH;
               col_n   = '0;
            end else begin
               col_n = col_cnt + 1'b1;
            end
         end
         ST_FLUSH: begin
            if (col_cnt == EDGE_END) begin
               col_n = '0;
               if (row_cnt == ROW_END) begin
                  state_n = ST_DONE;
                  row_n   = '0;
               end else begin
                  state_n = ST_FEED;
                  row_n   = row_cnt + 1'b1;
               end
            end else begin
               col_n = col_cnt + 1'b1;
            end
         end
         ST_DONE: begin
            state_n = start_ok ? ST_PRIME : ST_IDLE;
         end
         default: begin
            state_n = ST_IDLE;
            col_n   = '0;
            row_n   = '0;
         end
      endcase
   end

   assign s_ready = (state == ST_FEED);
   assign fir_x   = (s_ready && s_valid) ? s_data : '0;
   assign busy    = (state != ST_IDLE);
   assign done    = (state == ST_DONE);

   always_comb begin
      tag_in = '0;
      if (state == ST_FEED) begin
         tag_in.valid = 1'b1;
      end else if (state == ST_FLUSH) begin
         tag_in.valid    = 1'b1;
         tag_in.row_last = (col_cnt == EDGE_END);
         tag_in.frm_last = (col_cnt == EDGE_END) && (row_cnt == ROW_END);
      end
   end

   fir2d_tag_pipe #(.DEPTH(FILT_LAT)) u_tag_pipe (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (tag_in),
      .q     (tag_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_unrun <= 1'b0;
      end else if (start_ok) begin
         err_unrun <= 1'b0;
      end else if (s_ready && !s_valid) begin
         err_unrun <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid    <= 1'b0;
         m_data     <= '0;
         m_row_last <= 1'b0;
         m_frm_last <= 1'b0;
      end else begin
         m_valid    <= tag_out.valid;
         m_row_last <= tag_out.valid && tag_out.row_last;
         m_frm_last <= tag_out.valid && tag_out.frm_last;
         if (tag_out.valid) m_data <= sm_to_tc(fir_y);
      end
   end

endmodule

// File: tb/tb_fir2d_row_sched.sv
// Bench for fir2d_row_sched: a small 4x2 instance and a default 16x16 instance, each fed by a 4-tap FIR model.
module tb_fir2d_row_sched;

   localparam int T   = 4;
   localparam int L   = 1;
   localparam int W0  = 4;
   localparam int H0  = 2;
   localparam int W1  = 16;
   localparam int H1  = 16;
   localparam int TOT0 = H0 * (W0 + T - 1);

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        start_v   [2];
   logic        s_valid_v [2];
   logic [7:0]  s_data_v  [2];
   logic        s_ready_v [2];
   logic [7:0]  fir_x_v   [2];
   logic [11:0] fir_y0, fir_y1;
   logic        m_valid_v [2];
   logic [11:0] m_data_v  [2];
   logic        rl_v      [2];
   logic        fl_v      [2];
   logic        busy_v    [2];
   logic        done_v    [2];
   logic        err_v     [2];

   fir2d_row_sched #(.IMG_W(W0), .IMG_H(H0), .TAPS(T), .FILT_LAT(L)) dut_s (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .s_valid(s_valid_v[0]), .s_data(s_data_v[0]),
      .s_ready(s_ready_v[0]), .fir_x(fir_x_v[0]), .fir_y(fir_y0), .m_valid(m_valid_v[0]),
      .m_data(m_data_v[0]), .m_row_last(rl_v[0]), .m_frm_last(fl_v[0]), .busy(busy_v[0]),
      .done(done_v[0]), .err_unrun(err_v[0])
   );

   fir2d_row_sched #(.IMG_W(W1), .IMG_H(H1), .TAPS(T), .FILT_LAT(L)) dut_d (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .s_valid(s_valid_v[1]), .s_data(s_data_v[1]),
      .s_ready(s_ready_v[1]), .fir_x(fir_x_v[1]), .fir_y(fir_y1), .m_valid(m_valid_v[1]),
      .m_data(m_data_v[1]), .m_row_last(rl_v[1]), .m_frm_last(fl_v[1]), .busy(busy_v[1]),
      .done(done_v[1]), .err_unrun(err_v[1])
   );

   // Stand-in for filter_lut: one register stage, sign-magnitude output.
   int          coef [T] = '{2, -3, 1, 1};
   logic [7:0]  hist [2][T-1];
   logic [11:0] filt_y [2];
   logic        force_en  = 1'b0;
   logic [11:0] force_val = '0;

   function automatic logic [11:0] to_sm(input int v);
      int a;
      a = (v < 0) ? -v : v;
      return {(v < 0), a[10:0]};
   endfunction

   always @(posedge clk) begin : filt
      int acc;
      for (int c = 0; c < 2; c++) begin
         acc = coef[0] * int'(fir_x_v[c]);
         for (int k = 1; k < T; k++) acc += coef[k] * int'(hist[c][k-1]);
         filt_y[c] <= to_sm(acc);
         hist[c][0] <= fir_x_v[c];
         for (int k = 1; k < T - 1; k++) hist[c][k] <= hist[c][k-1];
      end
   end

   assign fir_y0 = force_en ? force_val : filt_y[0];
   assign fir_y1 = filt_y[1];

   // Output recorder
   int          cyc = 0;
   logic [13:0] obs_w [2][4096];
   int          obs_t [2][4096];
   int          obs_n [2] = '{0, 0};
   int          done_log [2][64];
   int          done_n [2] = '{0, 0};
   int          bad_tag = 0;

   always @(posedge clk) begin
      #1;
      cyc++;
      for (int c = 0; c < 2; c++) begin
         if (m_valid_v[c]) begin
            if (obs_n[c] < 4096) begin
               obs_w[c][obs_n[c]] = {rl_v[c], fl_v[c], m_data_v[c]};
               obs_t[c][obs_n[c]] = cyc;
               obs_n[c]++;
            end
         end else if (rl_v[c] || fl_v[c]) begin
            bad_tag++;
         end
         if (done_v[c] && done_n[c] < 64) begin
            done_log[c][done_n[c]] = cyc;
            done_n[c]++;
         end
      end
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   logic [7:0] pix [2][256];
   logic [7:0] fixed_px [8] = '{8'd6, 8'd9, 8'd0, 8'd2, 8'd11, 8'd36, 8'd21, 8'd2};
   logic       err_at_start;
   int         exp_base [2] = '{0, 0};
   int         dbase    [2] = '{0, 0};

   // Drives one frame on channel ch, recording the pixels actually taken into pix[f].
   task automatic run_frame(input int ch, input int f, input int unr_at, input bit use_fixed,
                            input bit poke, input bit chained, input bit chain_out);
      int np;
      bit fin;
      np  = 0;
      fin = 1'b0;
      if (!chained) begin
         @(negedge clk);
         start_v[ch] = 1'b1;
      end
      for (int i = 0; i < 2000 && !fin; i++) begin
         @(negedge clk);
         start_v[ch] = 1'b0;
         if (i == 0 && !chained) err_at_start = err_v[ch];
         if (done_v[ch]) begin
            fin = 1'b1;
            s_valid_v[ch] = 1'b0;
            if (chain_out) start_v[ch] = 1'b1;
         end else begin
            s_data_v[ch]  = use_fixed ? fixed_px[np % 8] : 8'($urandom);
            s_valid_v[ch] = s_ready_v[ch] ? (np != unr_at) : 1'($urandom);
            if (s_ready_v[ch]) begin
               if (np < 256) pix[f][np] = s_valid_v[ch] ? s_data_v[ch] : 8'd0;
               np++;
               if (poke && np == 2) start_v[ch] = 1'b1;
            end
         end
      end
      if (!fin) check("frame_timeout", 32'd0, 32'd1);
   endtask

   // Full convolution of each zero-padded row, compared with the recorded results.
   task automatic verify(input int ch, input int w, input int h, input int nfr);
      int tot, base, y, idx, last;
      logic [13:0] e;
      tot = h * (w + T - 1);
      check($sformatf("count c%0d", ch), obs_n[ch] - exp_base[ch], nfr * tot);
      for (int j = 0; j < nfr; j++) begin
         base = exp_base[ch] + j * tot;
         for (int r = 0; r < h; r++) begin
            for (int n = 0; n < w + T - 1; n++) begin
               y = 0;
               for (int k = 0; k < T; k++) begin
                  idx = n - k;
                  if (idx >= 0 && idx < w) y += coef[k] * int'(pix[j][r * w + idx]);
               end
               last = (n == w + T - 2) ? 1 : 0;
               e = {last[0], last[0] && (r == h - 1), y[11:0]};
               check($sformatf("res c%0d f%0d r%0d n%0d", ch, j, r, n),
                     obs_w[ch][base + r * (w + T - 1) + n], e);
            end
         end
         check($sformatf("contig c%0d f%0d", ch, j), obs_t[ch][base + tot - 1] - obs_t[ch][base], tot - 1);
         check($sformatf("done_lat c%0d f%0d", ch, j),
               obs_t[ch][base + tot - 1] - done_log[ch][dbase[ch] + j], L);
      end
      exp_base[ch] += nfr * tot;
      dbase[ch]    += nfr;
   endtask

   logic [11:0] fv [3] = '{12'h805, 12'h800, 12'h07F};
   logic [11:0] fe [3] = '{12'hFFB, 12'h000, 12'h07F};

   initial begin
      logic [13:0] o;
      for (int c = 0; c < 2; c++) begin
         start_v[c]   = 1'b0;
         s_valid_v[c] = 1'b0;
         s_data_v[c]  = '0;
      end
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int c = 0; c < 2; c++)
         check($sformatf("reset c%0d", c),
               {s_ready_v[c], fir_x_v[c], m_valid_v[c], m_data_v[c], rl_v[c], fl_v[c],
                busy_v[c], done_v[c], err_v[c]}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Asynchronous abort in the middle of FEED
      @(negedge clk);
      start_v[1] = 1'b1;
      @(negedge clk);
      start_v[1] = 1'b0;
      for (int i = 0; i < 100 && !m_valid_v[1]; i++) begin
         s_valid_v[1] = 1'b1;
         s_data_v[1]  = 8'($urandom);
         @(negedge clk);
      end
      check("midfeed_reach", {s_ready_v[1], m_valid_v[1]}, 32'd3);
      #2 rst_n = 1'b0;
      #1 check("async_rst", {busy_v[1], m_valid_v[1], s_ready_v[1]}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      s_valid_v[1] = 1'b0;
      repeat (2) @(negedge clk);
      exp_base[1] = obs_n[1];
      dbase[1]    = done_n[1];

      // Fixed 4x2 frame
      run_frame(0, 0, -1, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (L + 3) @(negedge clk);
      check("no_unrun", err_v[0], 32'd0);
      verify(0, W0, H0, 1);

      // Underrun in row 0
      run_frame(0, 0, 2, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (L + 3) @(negedge clk);
      check("unrun_set", err_v[0], 32'd1);
      verify(0, W0, H0, 1);
      repeat (5) @(negedge clk);
      check("unrun_held", err_v[0], 32'd1);

      // Sign-magnitude conversion on forced filter outputs
      for (int v = 0; v < 3; v++) begin
         force_val = fv[v];
         force_en  = 1'b1;
         run_frame(0, 0, -1, 1'b0, 1'b0, 1'b0, 1'b0);
         repeat (L + 3) @(negedge clk);
         if (v == 0) check("unrun_clr", {err_at_start, err_v[0]}, 32'd0);
         check($sformatf("force_cnt %0d", v), obs_n[0] - exp_base[0], TOT0);
         o = obs_w[0][exp_base[0] + 5];
         check($sformatf("conv %h", fv[v]), o[11:0], fe[v]);
         check($sformatf("hold %h", fv[v]), {m_valid_v[0], m_data_v[0]}, {20'd0, 1'b0, fe[v]});
         force_en    = 1'b0;
         exp_base[0] = obs_n[0];
         dbase[0]    = done_n[0];
      end

      // Start poked during FEED, then a start in the DONE cycle
      run_frame(0, 0, -1, 1'b0, 1'b1, 1'b0, 1'b1);
      run_frame(0, 1, -1, 1'b0, 1'b0, 1'b1, 1'b0);
      repeat (L + 3) @(negedge clk);
      verify(0, W0, H0, 2);

      // Back-to-back full-size frames
      run_frame(1, 0, -1, 1'b0, 1'b0, 1'b0, 1'b1);
      run_frame(1, 1, -1, 1'b0, 1'b0, 1'b1, 1'b0);
      repeat (L + 3) @(negedge clk);
      verify(1, W1, H1, 2);

      check("tag_idle", bad_tag, 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
